param_register_file: RTL and testbench
======================================

PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning data width of each register.
REQ-002 SHALL have parameter DEPTH, default 16, meaning number of registers; AW = clog2(DEPTH) is the address width.
REQ-003 SHALL have parameters SP_IDX=13, LR_IDX=14, PC_IDX=15, meaning indices of stack pointer, link register and program counter.
REQ-004 SHALL have parameters SP_RESET=16'h2000 and SP_LIMIT=16'h1F00, meaning the empty-stack value and the full-stack value of SP; PC_STEP=1, meaning the PC increment.
REQ-005 SHALL have ports: clock in 1, rising-edge clock; rst in 1, synchronous active-low reset.
REQ-006 we in 1 write enable; wr_addr in AW write index; wr_data in WIDTH write value.
REQ-007 rd_en in 1 read enable; rd_addr_a, rd_addr_b in AW read indices; rd_data_a, rd_data_b out WIDTH registered read data.
REQ-008 pc_inc in 1 advances PC; sp_op in 2 stack op (00 none, 01 push/decrement, 10 pop/increment, 11 none).
REQ-009 sp_out, pc_out out WIDTH current SP/PC contents; sp_fault out 1 stack over/underflow pulse.

Function
REQ-010 All register state SHALL update only on the rising edge of clock; no level-sensitive storage.
REQ-011 Explicit write: we=1 SHALL load wr_data into register wr_addr at the edge.
REQ-012 pc_inc=1 SHALL set PC to PC+PC_STEP modulo 2^WIDTH (wraps 0xFFFF -> 0x0000).
REQ-013 Push SHALL set SP to SP-1; pop SHALL set SP to SP+1.
REQ-014 Push with SP==SP_LIMIT SHALL leave SP unchanged and assert sp_fault for exactly the following cycle.
REQ-015 Pop with SP==SP_RESET SHALL leave SP unchanged and assert sp_fault for exactly the following cycle.
REQ-016 Explicit write to PC_IDX or SP_IDX SHALL take priority over pc_inc or sp_op in the same cycle; the overridden auto-op SHALL be discarded without fault.
REQ-017 Read latency SHALL be one cycle: with rd_en=1 at edge N, rd_data_a/b after edge N SHALL equal the post-edge-N contents of the addressed registers (write-through and auto-op bypass included).
REQ-018 rd_en=0 SHALL hold rd_data_a/b unchanged.
REQ-019 Both read ports MAY address the same register, including the one being written; both SHALL return the same value.
REQ-020 wr_addr, rd_addr_a or rd_addr_b >= DEPTH SHALL be ignored for write and SHALL read as zero.
REQ-021 sp_out and pc_out SHALL reflect register contents (registered, no bypass).

Reset
REQ-022 rst=0 at a rising edge SHALL set all registers to 0 except SP=SP_RESET, and set rd_data_a/b=0, sp_fault=0.
REQ-023 Reset SHALL override we, pc_inc, sp_op and rd_en in the same cycle; an operation in flight SHALL be lost.
REQ-024 Outputs after reset: pc_out=0, sp_out=SP_RESET.

Structure
REQ-025 Shared package SHALL hold default WIDTH/DEPTH, SP/LR/PC indices, SP_RESET, SP_LIMIT and the sp_op encoding constants.
REQ-026 One sub-module, reg_next_value, SHALL compute the post-edge value of a register from we/pc_inc/sp_op, reused by storage update and read bypass.

Verification
REQ-027 rst=0 one cycle, then rd_en=1, rd_addr_a=13, rd_addr_b=15 -> rd_data_a=0x2000, rd_data_b=0x0000, sp_fault=0.
REQ-028 we=1, wr_addr=3, wr_data=0xABCD, rd_en=1, rd_addr_a=3 same cycle -> next cycle rd_data_a=0xABCD.
REQ-029 pc written 0xFFFF, then pc_inc=1 -> pc_out=0x0000; pc_inc=1 with we to PC_IDX data 0x0040 -> pc_out=0x0040.
REQ-030 After reset, sp_op=10 -> SP stays 0x2000, sp_fault=1 one cycle; SP written 0x1F00 then sp_op=01 -> SP stays 0x1F00, sp_fault=1.
REQ-031 sp_op=01 three cycles then rst=0 mid-sequence -> sp_out=0x2000, sp_fault=0, rd_data_a/b=0.

Source files
------------

// File: rtl/param_register_file_pkg.sv
// Shared constants for the parameterised register file: default geometry, special-register roles, stack-op encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package param_register_file_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_SP_IDX   = 13;
    localparam int DEF_LR_IDX   = 14;
    localparam int DEF_PC_IDX   = 15;
    localparam int DEF_SP_RESET = 'h2000;
    localparam int DEF_SP_LIMIT = 'h1F00;
    localparam int DEF_PC_STEP  = 1;

    // Stack operation encoding on sp_op; 2'b11 is a reserved no-op.
    localparam logic [1:0] SP_OP_NONE = 2'b00;
    localparam logic [1:0] SP_OP_PUSH = 2'b01;
    localparam logic [1:0] SP_OP_POP  = 2'b10;
    localparam logic [1:0] SP_OP_RSVD = 2'b11;

endpackage

// File: rtl/param_register_file_reg_next_value.sv
// Post-edge value of one register from explicit write, PC advance and stack ops; flags stack over/underflow.
// Latency: combinational.
// Backpressure: none; always produces a value.
module reg_next_value
    import param_register_file_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter int               AW       = 4,
    parameter int               IDX      = 0,
    parameter int               SP_IDX   = DEF_SP_IDX,
    parameter int               PC_IDX   = DEF_PC_IDX,
    parameter logic [WIDTH-1:0] SP_RESET = WIDTH'(DEF_SP_RESET),
    parameter logic [WIDTH-1:0] SP_LIMIT = WIDTH'(DEF_SP_LIMIT),
    parameter int               PC_STEP  = DEF_PC_STEP
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pc_inc,
    input  logic [1:0]       sp_op,
    output logic [WIDTH-1:0] nxt,
    output logic             fault
);

    localparam logic [AW-1:0]    MY_ADDR = AW'(IDX);
    localparam bit               IS_PC   = (IDX == PC_IDX);
    localparam bit               IS_SP   = (IDX == SP_IDX);
    localparam logic [WIDTH-1:0] STEP    = WIDTH'(PC_STEP);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    // Explicit write wins; otherwise the role-specific auto-op applies. A refused stack op holds SP and faults.
    always_comb begin
        nxt   = cur;
        fault = 1'b0;
        if (we && (wr_addr == MY_ADDR)) begin
            nxt = wr_data;
        end else if (IS_PC) begin
            if (pc_inc) begin
                nxt = cur + STEP;
            end
        end else if (IS_SP) begin
            if (sp_op == SP_OP_PUSH) begin
                if (cur == SP_LIMIT) begin
                    fault = 1'b1;
                end else begin
                    nxt = cur - ONE;
                end
            end else if (sp_op == SP_OP_POP) begin
                if (cur == SP_RESET) begin
                    fault = 1'b1;
                end else begin
                    nxt = cur + ONE;
                end
            end
        end
    end

endmodule

// File: rtl/param_register_file.sv
// Register file with PC auto-increment, SP push/pop with limit checking and two bypassed registered read ports.
// Latency: one cycle for reads (post-edge contents visible after the edge); sp_fault one cycle after the refused op.
// Backpressure: none; every operation is accepted each cycle.
module param_register_file
    import param_register_file_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter int               DEPTH    = DEF_DEPTH,
    parameter int               SP_IDX   = DEF_SP_IDX,
    parameter int               LR_IDX   = DEF_LR_IDX,
    parameter int               PC_IDX   = DEF_PC_IDX,
    parameter logic [WIDTH-1:0] SP_RESET = WIDTH'(DEF_SP_RESET),
    parameter logic [WIDTH-1:0] SP_LIMIT = WIDTH'(DEF_SP_LIMIT),
    parameter int               PC_STEP  = DEF_PC_STEP,
    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic             pc_inc,
    input  logic [1:0]       sp_op,
    output logic [WIDTH-1:0] sp_out,
    output logic [WIDTH-1:0] pc_out,
    output logic             sp_fault
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] nxt  [DEPTH];
    logic [DEPTH-1:0] flt;
    logic [WIDTH-1:0] rd_next_a;
    logic [WIDTH-1:0] rd_next_b;

    // LR is an ordinary register; its index is kept for software conventions only.
    localparam int LR_ROLE = LR_IDX;

    // One next-value unit per register; the same results feed storage and the read bypass.
    for (genvar i = 0; i < DEPTH; i++) begin : g_nv
        reg_next_value #(
            .WIDTH    (WIDTH),
            .AW       (AW),
            .IDX      (i),
            .SP_IDX   (SP_IDX),
            .PC_IDX   (PC_IDX),
            .SP_RESET (SP_RESET),
            .SP_LIMIT (SP_LIMIT),
            .PC_STEP  (PC_STEP)
        ) u_nv (
            .cur     (regs[i]),
            .we      (we),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .pc_inc  (pc_inc),
            .sp_op   (sp_op),
            .nxt     (nxt[i]),
            .fault   (flt[i])
        );
    end

    // Read muxes select post-edge values so a same-cycle write or auto-op is visible; out-of-range reads as zero.
    always_comb begin
        rd_next_a = '0;
        rd_next_b = '0;
        if (int'(rd_addr_a) < DEPTH) begin
            rd_next_a = nxt[rd_addr_a];
        end
        if (int'(rd_addr_b) < DEPTH) begin
            rd_next_b = nxt[rd_addr_b];
        end
    end

    // Storage, registered read ports and fault pulse; reset clears everything except SP.
    always_ff @(posedge clock) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
            end
            rd_data_a <= '0;
            rd_data_b <= '0;
            sp_fault  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= nxt[i];
            end
            if (rd_en) begin
                rd_data_a <= rd_next_a;
                rd_data_b <= rd_next_b;
            end
            // Only the SP unit can raise a fault, so the OR is the SP fault.
            sp_fault <= |flt;
        end
    end

    assign sp_out = regs[SP_IDX];
    assign pc_out = regs[PC_IDX];

endmodule

// File: tb/tb_param_register_file.sv
// Randomised and directed scoreboard bench for param_register_file against an array-based reference model.
// Latency: expectations are pushed at stimulus time and popped one edge later by the monitor.
// Backpressure: n/a.
module tb_param_register_file;

    logic        clock = 1'b0;
    logic        rst;
    logic        we;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic        pc_inc;
    logic [1:0]  sp_op;
    logic [15:0] sp_out;
    logic [15:0] pc_out;
    logic        sp_fault;

    always #5 clock = ~clock;

    param_register_file dut (
        .clock     (clock),
        .rst       (rst),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .pc_inc    (pc_inc),
        .sp_op     (sp_op),
        .sp_out    (sp_out),
        .pc_out    (pc_out),
        .sp_fault  (sp_fault)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sp;
        logic [15:0] pc;
        logic        f;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    // Reference state: a plain array of register values plus the last read results.
    logic [15:0] m_reg [16];
    logic [15:0] m_a;
    logic [15:0] m_b;
    int          n_vec  = 0;
    int          n_miss = 0;
    int          cyc_no = 0;

    task automatic chk(input string name, input int cyc, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Apply one cycle of stimulus and record what the outputs must be after the next rising edge.
    task automatic cyc(input logic r, input logic w, input logic [3:0] wa, input logic [15:0] wd,
                       input logic re, input logic [3:0] aa, input logic [3:0] ab,
                       input logic pi, input logic [1:0] so);
        logic [15:0] nm [16];
        logic        f;
        exp_t        e;
        @(negedge clock);
        rst = r; we = w; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_addr_a = aa; rd_addr_b = ab; pc_inc = pi; sp_op = so;
        f = 1'b0;
        if (!r) begin
            for (int i = 0; i < 16; i++) m_reg[i] = 16'h0000;
            m_reg[13] = 16'h2000;
            m_a = 16'h0000;
            m_b = 16'h0000;
        end else begin
            nm = m_reg;
            if (pi) nm[15] = m_reg[15] + 16'd1;
            if (so == 2'b01) begin
                if (m_reg[13] == 16'h1F00) f = 1'b1;
                else nm[13] = m_reg[13] - 16'd1;
            end else if (so == 2'b10) begin
                if (m_reg[13] == 16'h2000) f = 1'b1;
                else nm[13] = m_reg[13] + 16'd1;
            end
            if (w) begin
                nm[wa] = wd;
                if (wa == 4'd13) f = 1'b0;
            end
            m_reg = nm;
            if (re) begin
                m_a = m_reg[aa];
                m_b = m_reg[ab];
            end
        end
        cyc_no++;
        e.a = m_a; e.b = m_b; e.sp = m_reg[13]; e.pc = m_reg[15]; e.f = f; e.cyc = cyc_no;
        sb.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle, so one expectation is consumed per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rd_data_a", e.cyc, rd_data_a, e.a);
                chk("rd_data_b", e.cyc, rd_data_b, e.b);
                chk("sp_out",    e.cyc, sp_out,    e.sp);
                chk("pc_out",    e.cyc, pc_out,    e.pc);
                chk("sp_fault",  e.cyc, {15'd0, sp_fault}, {15'd0, e.f});
            end
        end
    end

    initial begin
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [3:0]  aa;
        logic [3:0]  ab;
        logic        w;
        rst = 1'b1; we = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr_a = '0; rd_addr_b = '0; pc_inc = 1'b0; sp_op = 2'b00;

        // Reset, then read SP and PC.
        cyc(0, 0, 0, 0,        0, 0,  0,  0, 2'b00);
        cyc(1, 0, 0, 0,        1, 13, 15, 0, 2'b00);
        // Write-through to both ports on the written register.
        cyc(1, 1, 3, 16'hABCD, 1, 3,  3,  0, 2'b00);
        cyc(1, 0, 0, 0,        1, 3,  13, 0, 2'b00);
        // PC wrap and write-over-increment priority.
        cyc(1, 1, 15, 16'hFFFF, 0, 0, 0,  0, 2'b00);
        cyc(1, 0, 0, 0,        1, 15, 15, 1, 2'b00);
        cyc(1, 1, 15, 16'h0040, 1, 15, 14, 1, 2'b00);
        // Underflow on empty stack, then overflow at the limit.
        cyc(0, 0, 0, 0,        0, 0,  0,  0, 2'b00);
        cyc(1, 0, 0, 0,        1, 13, 0,  0, 2'b10);
        cyc(1, 0, 0, 0,        0, 0,  0,  0, 2'b00);
        cyc(1, 1, 13, 16'h1F00, 0, 0, 0,  0, 2'b00);
        cyc(1, 0, 0, 0,        1, 13, 13, 0, 2'b01);
        cyc(1, 0, 0, 0,        0, 0,  0,  0, 2'b00);
        // Write to SP overrides a faulting push without a fault.
        cyc(1, 1, 13, 16'h1F00, 1, 13, 13, 0, 2'b01);
        // Pushes interrupted by reset carrying other operations.
        cyc(1, 1, 13, 16'h2000, 0, 0, 0,  0, 2'b00);
        cyc(1, 0, 0, 0,        1, 13, 15, 0, 2'b01);
        cyc(1, 0, 0, 0,        1, 13, 15, 1, 2'b01);
        cyc(0, 1, 2, 16'h5555, 1, 13, 2,  1, 2'b01);
        // rd_en low holds the read ports.
        cyc(1, 1, 5, 16'h1234, 1, 5,  5,  0, 2'b00);
        cyc(1, 1, 5, 16'h9999, 0, 5,  5,  0, 2'b00);

        // Randomised traffic with SP writes biased toward the limits.
        for (int n = 0; n < 1500; n++) begin
            w  = ($urandom_range(0, 9) < 4);
            wa = 4'($urandom_range(0, 15));
            wd = 16'($urandom);
            if ($urandom_range(0, 3) == 0) wa = 4'd13;
            if (wa == 4'd13) begin
                case ($urandom_range(0, 4))
                    0: wd = 16'h1F00;
                    1: wd = 16'h1F01;
                    2: wd = 16'h2000;
                    3: wd = 16'h1FFF;
                    default: ;
                endcase
            end
            if ($urandom_range(0, 7) == 0) begin
                wa = 4'd15;
                wd = 16'hFFFF;
            end
            aa = 4'($urandom_range(0, 15));
            ab = ($urandom_range(0, 3) == 0) ? aa : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) aa = wa;
            cyc(($urandom_range(0, 49) != 0), w, wa, wd, ($urandom_range(0, 3) != 0), aa, ab,
                1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end

        cyc(1, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        repeat (3) @(posedge clock);
        #2;
        chk("scoreboard_drain", cyc_no, 16'(sb.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
